// File: rtl/prbs31_checker_32b.sv
// PRBS31 checker for 32-bit words: searches for LOCK_CNT consecutive self-consistent
// words, then freewheels the expected sequence and counts bit/word errors.
module prbs31_checker_32b #(
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned UNLOCK_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic        din_valid,
  input  logic        clear_cnt,
  output logic        locked,
  output logic        err_flag,
  output logic [31:0] err_bit_cnt,
  output logic [31:0] err_word_cnt,
  output logic [15:0] unlock_cnt
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  // One 32-bit advance of the PRBS31 generator.
  function automatic logic [31:0] prbs_next(input logic [31:0] p);
    logic [31:4] h;
    logic [31:0] f;
    h       = p[30:3] ^ p[27:0];
    f[31:4] = h;
    f[3:0]  = {p[2:0], h[31]} ^ h[31:28];
    return f;
  endfunction

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  state_t         state;
  logic [31:0]    prev_din;
  logic           prev_ok;
  logic [31:0]    exp_word;
  logic [MW-1:0]  match_cnt;
  logic [BW-1:0]  bad_cnt;

  logic [31:0] mism;
  logic        has_err;
  logic        search_hit;
  logic [32:0] bit_sum;
  logic [31:0] bit_cnt_nxt;
  logic [31:0] word_cnt_nxt;
  logic [15:0] unlock_cnt_nxt;

  // Datapath: mismatch, self-sync compare and saturating counter increments.
  always_comb begin
    mism           = din ^ exp_word;
    has_err        = |mism;
    search_hit     = prev_ok && (din == prbs_next(prev_din));
    bit_sum        = {1'b0, err_bit_cnt} + 33'(popcount32(mism));
    bit_cnt_nxt    = bit_sum[32] ? 32'hffff_ffff : bit_sum[31:0];
    word_cnt_nxt   = (&err_word_cnt) ? err_word_cnt : err_word_cnt + 32'd1;
    unlock_cnt_nxt = (&unlock_cnt) ? unlock_cnt : unlock_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SEARCH;
      locked       <= 1'b0;
      err_flag     <= 1'b0;
      err_bit_cnt  <= 32'd0;
      err_word_cnt <= 32'd0;
      unlock_cnt   <= 16'd0;
      prev_din     <= 32'd0;
      prev_ok      <= 1'b0;
      exp_word     <= 32'd0;
      match_cnt    <= MW'(0);
      bad_cnt      <= BW'(0);
    end else begin
      err_flag <= 1'b0;
      if (din_valid) begin
        case (state)
          SEARCH: begin
            prev_din <= din;
            prev_ok  <= 1'b1;
            if (search_hit) begin
              match_cnt <= match_cnt + MW'(1);
              if (match_cnt == MW'(LOCK_CNT - 1)) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                exp_word <= prbs_next(din);
                bad_cnt  <= BW'(0);
              end
            end else begin
              match_cnt <= MW'(0);
            end
          end
          LOCKED: begin
            // Expected sequence freewheels; errored input never reseeds it.
            exp_word <= prbs_next(exp_word);
            if (has_err) begin
              err_flag     <= 1'b1;
              err_bit_cnt  <= bit_cnt_nxt;
              err_word_cnt <= word_cnt_nxt;
              if (bad_cnt == BW'(UNLOCK_CNT - 1)) begin
                state      <= SEARCH;
                locked     <= 1'b0;
                match_cnt  <= MW'(0);
                prev_din   <= din;
                prev_ok    <= 1'b1;
                bad_cnt    <= BW'(0);
                unlock_cnt <= unlock_cnt_nxt;
              end else begin
                bad_cnt <= bad_cnt + BW'(1);
              end
            end else begin
              bad_cnt <= BW'(0);
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
      // Clear wins over any increment made above in the same cycle.
      if (clear_cnt) begin
        err_bit_cnt  <= 32'd0;
        err_word_cnt <= 32'd0;
        unlock_cnt   <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_prbs31_checker_32b.sv
// Directed testbench for prbs31_checker_32b (default LOCK_CNT=8, UNLOCK_CNT=4).
module tb_prbs31_checker_32b;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = 32'd0;
  logic        din_valid = 1'b0;
  logic        clear_cnt = 1'b0;
  logic        locked;
  logic        err_flag;
  logic [31:0] err_bit_cnt;
  logic [31:0] err_word_cnt;
  logic [15:0] unlock_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] g;

  prbs31_checker_32b dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
    .locked(locked), .err_flag(err_flag), .err_bit_cnt(err_bit_cnt),
    .err_word_cnt(err_word_cnt), .unlock_cnt(unlock_cnt)
  );

  always #5 clk = ~clk;

  // Generator step written out per output bit.
  function automatic logic [31:0] gen_next(input logic [31:0] p);
    logic [31:0] f;
    for (int i = 4; i < 32; i++) f[i] = p[i-1] ^ p[i-4];
    f[3] = p[2] ^ p[30] ^ p[27];
    f[2] = p[1] ^ p[29] ^ p[26];
    f[1] = p[0] ^ p[28] ^ p[25];
    f[0] = p[30] ^ p[24];
    return f;
  endfunction

  // Present one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic [31:0] d, input logic v, input logic clr);
    @(negedge clk);
    din = d; din_valid = v; clear_cnt = clr;
    @(posedge clk);
    #1;
    din_valid = 1'b0; clear_cnt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b1; din = 32'hdead_beef; clear_cnt = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; din_valid = 1'b0;
  endtask

  task automatic do_lock();
    g = 32'hffff_ffff;
    for (int i = 0; i < 9; i++) begin
      step(g, 1'b1, 1'b0);
      g = gen_next(g);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (locked !== 1'b0) $display("FAIL reset_locked got %0b want 0", locked); else pass_cnt++;
    total_cnt++; if (err_flag !== 1'b0) $display("FAIL reset_err_flag got %0b want 0", err_flag); else pass_cnt++;
    total_cnt++; if (err_bit_cnt !== 32'd0) $display("FAIL reset_bit_cnt got %0d want 0", err_bit_cnt); else pass_cnt++;
    total_cnt++; if (err_word_cnt !== 32'd0) $display("FAIL reset_word_cnt got %0d want 0", err_word_cnt); else pass_cnt++;
    total_cnt++; if (unlock_cnt !== 16'd0) $display("FAIL reset_unlock_cnt got %0d want 0", unlock_cnt); else pass_cnt++;
  endtask

  task automatic test_clean_lock();
    g = 32'hffff_ffff;
    for (int i = 0; i < 9; i++) begin
      step(g, 1'b1, 1'b0);
      g = gen_next(g);
      if (i == 7) begin
        total_cnt++; if (locked !== 1'b0) $display("FAIL clean_early_lock got %0b want 0", locked); else pass_cnt++;
      end
    end
    total_cnt++; if (locked !== 1'b1) $display("FAIL clean_locked got %0b want 1", locked); else pass_cnt++;
    total_cnt++; if (err_bit_cnt !== 32'd0) $display("FAIL clean_bit_cnt got %0d want 0", err_bit_cnt); else pass_cnt++;
    total_cnt++; if (err_word_cnt !== 32'd0) $display("FAIL clean_word_cnt got %0d want 0", err_word_cnt); else pass_cnt++;
  endtask

  task automatic test_single_bit();
    step(g ^ 32'd1, 1'b1, 1'b0);
    g = gen_next(g);
    total_cnt++; if (err_flag !== 1'b1) $display("FAIL sb_err_flag got %0b want 1", err_flag); else pass_cnt++;
    total_cnt++; if (err_bit_cnt !== 32'd1) $display("FAIL sb_bit_cnt got %0d want 1", err_bit_cnt); else pass_cnt++;
    total_cnt++; if (err_word_cnt !== 32'd1) $display("FAIL sb_word_cnt got %0d want 1", err_word_cnt); else pass_cnt++;
    total_cnt++; if (locked !== 1'b1) $display("FAIL sb_locked got %0b want 1", locked); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step(g, 1'b1, 1'b0);
      g = gen_next(g);
      total_cnt++; if (err_flag !== 1'b0) $display("FAIL sb_clean_flag[%0d] got %0b want 0", i, err_flag); else pass_cnt++;
    end
    total_cnt++; if (err_bit_cnt !== 32'd1) $display("FAIL sb_bit_cnt_after got %0d want 1", err_bit_cnt); else pass_cnt++;
    total_cnt++; if (locked !== 1'b1) $display("FAIL sb_locked_after got %0b want 1", locked); else pass_cnt++;
  endtask

  task automatic test_lock_loss();
    do_reset();
    do_lock();
    for (int i = 0; i < 4; i++) begin
      step(~g, 1'b1, 1'b0);
      g = gen_next(g);
      if (i == 2) begin
        total_cnt++; if (locked !== 1'b1) $display("FAIL ll_locked_3rd got %0b want 1", locked); else pass_cnt++;
      end
    end
    total_cnt++; if (locked !== 1'b0) $display("FAIL ll_locked got %0b want 0", locked); else pass_cnt++;
    total_cnt++; if (err_bit_cnt !== 32'd128) $display("FAIL ll_bit_cnt got %0d want 128", err_bit_cnt); else pass_cnt++;
    total_cnt++; if (err_word_cnt !== 32'd4) $display("FAIL ll_word_cnt got %0d want 4", err_word_cnt); else pass_cnt++;
    total_cnt++; if (unlock_cnt !== 16'd1) $display("FAIL ll_unlock_cnt got %0d want 1", unlock_cnt); else pass_cnt++;
    total_cnt++; if (err_flag !== 1'b1) $display("FAIL ll_err_flag got %0b want 1", err_flag); else pass_cnt++;
    for (int i = 0; i < 9; i++) begin
      step(g, 1'b1, 1'b0);
      g = gen_next(g);
      if (i == 7) begin
        total_cnt++; if (locked !== 1'b0) $display("FAIL ll_relock_early got %0b want 0", locked); else pass_cnt++;
      end
    end
    total_cnt++; if (locked !== 1'b1) $display("FAIL ll_relock got %0b want 1", locked); else pass_cnt++;
    total_cnt++; if (err_word_cnt !== 32'd4) $display("FAIL ll_search_no_count got %0d want 4", err_word_cnt); else pass_cnt++;
  endtask

  task automatic test_gap();
    do_reset();
    g = 32'hffff_ffff;
    for (int i = 0; i < 9; i++) begin
      step(g, 1'b1, 1'b0);
      g = gen_next(g);
      if (i == 7) begin
        total_cnt++; if (locked !== 1'b0) $display("FAIL gap_early_lock got %0b want 0", locked); else pass_cnt++;
      end
      if (i < 8) begin
        step(~g, 1'b0, 1'b0);
        total_cnt++; if (err_flag !== 1'b0) $display("FAIL gap_idle_flag[%0d] got %0b want 0", i, err_flag); else pass_cnt++;
      end
    end
    total_cnt++; if (locked !== 1'b1) $display("FAIL gap_locked got %0b want 1", locked); else pass_cnt++;
    step(32'd0, 1'b0, 1'b0);
    step(g, 1'b1, 1'b0);
    g = gen_next(g);
    total_cnt++; if (err_flag !== 1'b0) $display("FAIL gap_locked_flag got %0b want 0", err_flag); else pass_cnt++;
    total_cnt++; if (err_word_cnt !== 32'd0) $display("FAIL gap_word_cnt got %0d want 0", err_word_cnt); else pass_cnt++;
  endtask

  task automatic test_clear_priority();
    step(g ^ 32'h8000_0001, 1'b1, 1'b0);
    g = gen_next(g);
    total_cnt++; if (err_bit_cnt !== 32'd2) $display("FAIL clr_pre_bit_cnt got %0d want 2", err_bit_cnt); else pass_cnt++;
    step(g ^ 32'd3, 1'b1, 1'b1);
    g = gen_next(g);
    total_cnt++; if (err_bit_cnt !== 32'd0) $display("FAIL clr_bit_cnt got %0d want 0", err_bit_cnt); else pass_cnt++;
    total_cnt++; if (err_word_cnt !== 32'd0) $display("FAIL clr_word_cnt got %0d want 0", err_word_cnt); else pass_cnt++;
    total_cnt++; if (err_flag !== 1'b1) $display("FAIL clr_err_flag got %0b want 1", err_flag); else pass_cnt++;
    total_cnt++; if (locked !== 1'b1) $display("FAIL clr_locked got %0b want 1", locked); else pass_cnt++;
  endtask

  task automatic test_mid_lock_reset();
    step(g ^ 32'hf, 1'b1, 1'b0);
    g = gen_next(g);
    do_reset();
    total_cnt++; if (locked !== 1'b0) $display("FAIL mlr_locked got %0b want 0", locked); else pass_cnt++;
    total_cnt++; if (err_bit_cnt !== 32'd0) $display("FAIL mlr_bit_cnt got %0d want 0", err_bit_cnt); else pass_cnt++;
    total_cnt++; if (err_flag !== 1'b0) $display("FAIL mlr_err_flag got %0b want 0", err_flag); else pass_cnt++;
    for (int i = 0; i < 9; i++) begin
      step(g, 1'b1, 1'b0);
      g = gen_next(g);
      if (i == 7) begin
        total_cnt++; if (locked !== 1'b0) $display("FAIL mlr_early_lock got %0b want 0", locked); else pass_cnt++;
      end
    end
    total_cnt++; if (locked !== 1'b1) $display("FAIL mlr_relock got %0b want 1", locked); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_bit();
    test_lock_loss();
    test_gap();
    test_clear_priority();
    test_mid_lock_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
